// File: rtl/nmi_guard_pkg.sv
// nmi_guard_pkg
// Shared types and helpers for the NMI bus guard.
//   guard_state_e     : request FSM states (IDLE, REQ, RESP)
//   DEFAULT_ERR_RDATA : read data handed back to the core when a transfer times out
//   cnt_width()       : width of the watchdog counter for a given timeout
package nmi_guard_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} guard_state_e;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    // A disabled watchdog (timeout 0) would give a zero-width counter,
    // so the width is clamped to at least one bit.
    function automatic int cnt_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nmi_if.sv
// nmi_if
// Native memory interface bundle (PicoRV32-style).
//   valid/addr/wdata/wstrb : request, driven by the master
//   ready/rdata            : response, driven by the slave
// A non-zero wstrb marks a write, zero marks a read.
interface nmi_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_bus_guard_irq_cond.sv
// irq_cond
// Interrupt conditioning: a two-flop synchroniser per line, followed by
// either a registered level pass-through or a rising-edge pending latch.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   raw      : asynchronous interrupt sources
//   clr      : one-cycle clear pulses (edge lines only)
//   lines    : registered conditioned interrupt lines
module irq_cond #(
    parameter int                 NUM_IRQ       = 16,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] raw,
    input  logic [NUM_IRQ-1:0] clr,
    output logic [NUM_IRQ-1:0] lines
);

    logic [NUM_IRQ-1:0] sync0;
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] edge_next;
    logic [NUM_IRQ-1:0] line_next;

    // Edge lines: a new rising edge beats a coincident clear.
    // Level lines simply follow the synchronised input one cycle later.
    always_comb begin
        rise      = sync1 & ~prev;
        edge_next = rise | (lines & ~clr);
        line_next = (IRQ_EDGE_MASK & edge_next) | (~IRQ_EDGE_MASK & sync1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= '0;
            sync1 <= '0;
            prev  <= '0;
            lines <= '0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            prev  <= sync1;
            lines <= line_next;
        end
    end

endmodule

// File: rtl/nmi_bus_guard.sv
// nmi_bus_guard
// Registered request stage plus bus-timeout watchdog between the management
// core's native memory port and the SoC fabric, and IRQ conditioning for
// the core's 32-bit irq input.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   core_nmi      : slave port facing the core
//   soc_nmi       : registered master port facing the fabric
//   irq_raw_i     : asynchronous interrupt sources
//   irq_clr_i     : clear pulses for edge-latched pending bits
//   irq_o         : conditioned IRQ vector (bits >= NUM_IRQ are 0)
//   err_o         : sticky timeout flag
//   err_addr_o    : address of the first timed-out transfer since last clear
//   err_clr_i     : clears err_o and re-arms err_addr_o capture
// Optional: define NMI_GUARD_STAT_EN to add stat_xfer_o (completed transfers)
// and stat_tmo_o (timeouts), both saturating and cleared by err_clr_i.
module nmi_bus_guard
    import nmi_guard_pkg::*;
#(
    parameter int                 TIMEOUT_CYC   = 1024,
    parameter logic [31:0]        ERR_RDATA     = DEFAULT_ERR_RDATA,
    parameter int                 NUM_IRQ       = 16,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    nmi_if.slave               core_nmi,
    nmi_if.master              soc_nmi,
    input  logic [NUM_IRQ-1:0] irq_raw_i,
    input  logic [NUM_IRQ-1:0] irq_clr_i,
    output logic [31:0]        irq_o,
    output logic               err_o,
    input  logic               err_clr_i,
    output logic [31:0]        err_addr_o
`ifdef NMI_GUARD_STAT_EN
    ,
    output logic [31:0]        stat_xfer_o,
    output logic [15:0]        stat_tmo_o
`endif
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    guard_state_e       state;
    logic               soc_valid;
    logic               core_ready;
    logic [31:0]        rdata_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [CNT_W-1:0]   cnt;
    logic               tmo_hit;
    logic [NUM_IRQ-1:0] irq_lines;

    // The fabric only ever sees the request registers, never the core's
    // combinational outputs, so core-to-fabric timing paths are cut.
    assign soc_nmi.valid  = soc_valid;
    assign soc_nmi.addr   = addr_q;
    assign soc_nmi.wdata  = wdata_q;
    assign soc_nmi.wstrb  = wstrb_q;
    assign core_nmi.ready = core_ready;
    assign core_nmi.rdata = rdata_q;

    // Fabric ready takes priority over an expiring watchdog in the same cycle.
    assign tmo_hit = (state == REQ) && !soc_nmi.ready && (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

    // Request FSM: capture in IDLE, wait for the fabric (or the watchdog) in
    // REQ, hand the response to the core for exactly one cycle in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            soc_valid  <= 1'b0;
            core_ready <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_nmi.valid) begin
                        addr_q    <= core_nmi.addr;
                        wdata_q   <= core_nmi.wdata;
                        wstrb_q   <= core_nmi.wstrb;
                        cnt       <= '0;
                        soc_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (soc_nmi.ready) begin
                        rdata_q    <= soc_nmi.rdata;
                        soc_valid  <= 1'b0;
                        core_ready <= 1'b1;
                        state      <= RESP;
                    end else if (tmo_hit) begin
                        rdata_q    <= ERR_RDATA;
                        soc_valid  <= 1'b0;
                        core_ready <= 1'b1;
                        state      <= RESP;
                    end else if (TIMEOUT_CYC != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    core_ready <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flag. A timeout beats a coincident clear, and the address
    // is captured only when the flag is (or is being) cleared: first fault wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else begin
            if (tmo_hit) begin
                err_o <= 1'b1;
                if (!err_o || err_clr_i) begin
                    err_addr_o <= addr_q;
                end
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

`ifdef NMI_GUARD_STAT_EN
    // Saturating statistics; an increment beats a coincident clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_xfer_o <= '0;
            stat_tmo_o  <= '0;
        end else begin
            if (state == RESP) begin
                if (stat_xfer_o != '1) begin
                    stat_xfer_o <= stat_xfer_o + 32'd1;
                end
            end else if (err_clr_i) begin
                stat_xfer_o <= '0;
            end
            if (tmo_hit) begin
                if (stat_tmo_o != '1) begin
                    stat_tmo_o <= stat_tmo_o + 16'd1;
                end
            end else if (err_clr_i) begin
                stat_tmo_o <= '0;
            end
        end
    end
`endif

    irq_cond #(
        .NUM_IRQ       (NUM_IRQ),
        .IRQ_EDGE_MASK (IRQ_EDGE_MASK)
    ) u_irq_cond (
        .clk   (clk_i),
        .rst   (rst_i),
        .raw   (irq_raw_i),
        .clr   (irq_clr_i),
        .lines (irq_lines)
    );

    // Lines above NUM_IRQ are tied low.
    always_comb begin
        irq_o              = '0;
        irq_o[NUM_IRQ-1:0] = irq_lines;
    end

endmodule
